// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: memory-mapped register bus used by the keypad scan controller.
// The master drives write/read addresses, byte enables and write data; the slave returns registered read data.
interface keypad_scan_ctrl_if;
    logic [7:0]  addrIn;
    logic [7:0]  addrOut;
    logic [3:0]  sizeDecode;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    modport master (
        output addrIn,
        output addrOut,
        output sizeDecode,
        output dataIn,
        input  dataOut
    );

    modport slave (
        input  addrIn,
        input  addrOut,
        input  sizeDecode,
        input  dataIn,
        output dataOut
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: paced 4x4 keypad row scanner with whole-frame debounce and an event FIFO.
// Optional feature macro: KEYPAD_RELEASE_EVENT_EN -- when defined, key releases are queued as
// events alongside presses; when undefined only presses are queued.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    keypad_scan_ctrl_if.slave bus,
    input  logic [3:0]        COL,
    output logic [3:0]        ROW,
    output logic              irq
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);

`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam bit RELEASE_EVENTS = 1'b1;
`else
    localparam bit RELEASE_EVENTS = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        EMIT
    } state_t;

    state_t          state;
    logic [1:0]      rowIdx;
    logic [DIVW-1:0] divCnt;
    logic [3:0]      emitIdx;
    logic [15:0]     frameBuf;
    logic [15:0]     prevFrame;
    logic [3:0]      dbCnt;
    logic [15:0]     stable;
    logic [15:0]     diffMask;

    logic [15:0]     curFrame;
    logic [3:0]      nextCnt;
    logic            commit;

    logic [1:0]      ctrl;
    logic            overflow;
    logic [4:0]      fifoMem [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [CW-1:0]   count;

    logic            pushReq;
    logic [4:0]      pushData;
    logic            push;
    logic            pop;
    logic            wrEn;
    logic            ctrlWr;
    logic            popReq;
    logic            fifoEmpty;
    logic            fifoFull;
    logic [4:0]      countWide;
    logic [3:0]      countField;
    logic [31:0]     rdData;
    logic            unusedDataBits;

    assign wrEn      = |bus.sizeDecode;
    assign ctrlWr    = wrEn && (bus.addrIn == 8'd2);
    assign popReq    = wrEn && (bus.addrIn == 8'd1);
    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == CW'(FIFO_DEPTH));
    assign pop       = popReq && !fifoEmpty;
    assign push      = pushReq && (!fifoFull || pop);
    assign unusedDataBits = ^bus.dataIn[31:3];

    // Assemble the full frame (row 3 is live on COL during its sample cycle) and compute the debounce step.
    always_comb begin
        curFrame        = frameBuf;
        curFrame[15:12] = ~COL;
        if (curFrame != prevFrame) begin
            nextCnt = 4'd1;
        end else if (dbCnt == 4'hF) begin
            nextCnt = 4'hF;
        end else begin
            nextCnt = dbCnt + 4'd1;
        end
        commit = (nextCnt >= 4'(DEBOUNCE_SCANS)) && (curFrame != stable);
    end

    // During EMIT, walk the changed bits and request a FIFO push for each reportable transition.
    always_comb begin
        pushReq  = 1'b0;
        pushData = {stable[emitIdx], emitIdx};
        if ((state == EMIT) && diffMask[emitIdx] && (stable[emitIdx] || RELEASE_EVENTS)) begin
            pushReq = 1'b1;
        end
    end

    // Scan sequencer: paced row drive, per-row capture, frame debounce, and the 16-cycle event walk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ROW       <= 4'hF;
            rowIdx    <= '0;
            divCnt    <= '0;
            emitIdx   <= '0;
            frameBuf  <= '0;
            prevFrame <= '0;
            dbCnt     <= '0;
            stable    <= '0;
            diffMask  <= '0;
        end else if (!ctrl[0]) begin
            state     <= IDLE;
            ROW       <= 4'hF;
            rowIdx    <= '0;
            divCnt    <= '0;
            emitIdx   <= '0;
            frameBuf  <= '0;
            prevFrame <= '0;
            dbCnt     <= '0;
            diffMask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= DRIVE;
                    rowIdx <= 2'd0;
                    divCnt <= '0;
                    ROW    <= 4'b1110;
                end
                DRIVE: begin
                    if (divCnt == DIV_LAST) begin
                        state  <= SAMPLE;
                        divCnt <= '0;
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    frameBuf[{rowIdx, 2'b00} +: 4] <= ~COL;
                    if (rowIdx == 2'd3) begin
                        prevFrame <= curFrame;
                        dbCnt     <= nextCnt;
                        rowIdx    <= 2'd0;
                        if (commit) begin
                            stable   <= curFrame;
                            diffMask <= stable ^ curFrame;
                            emitIdx  <= '0;
                            state    <= EMIT;
                            ROW      <= 4'hF;
                        end else begin
                            state <= DRIVE;
                            ROW   <= 4'b1110;
                        end
                    end else begin
                        rowIdx <= rowIdx + 2'd1;
                        state  <= DRIVE;
                        ROW    <= ~(4'b0001 << (rowIdx + 2'd1));
                    end
                end
                EMIT: begin
                    if (emitIdx == 4'hF) begin
                        state   <= DRIVE;
                        emitIdx <= '0;
                        ROW     <= 4'b1110;
                    end else begin
                        emitIdx <= emitIdx + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ROW   <= 4'hF;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the control register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ctrl     <= 2'b00;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            if (pushReq && !push) begin
                overflow <= 1'b1;
            end else if (ctrlWr && bus.dataIn[2]) begin
                overflow <= 1'b0;
            end
            if (ctrlWr) begin
                ctrl <= bus.dataIn[1:0];
            end
        end
    end

    // Event storage; contents are only meaningful between rdPtr and wrPtr, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= pushData;
        end
    end

    // Read mux; the count field saturates at 15 so a full 16-deep FIFO never reads back as empty.
    always_comb begin
        countWide  = 5'(count);
        countField = (countWide > 5'd15) ? 4'hF : countWide[3:0];
        case (bus.addrOut)
            8'd0:    rdData = {stable, 4'h0, countField, 6'h0, overflow, !fifoEmpty};
            8'd1:    rdData = fifoEmpty ? 32'hFFFF_FFFF : {27'h0, fifoMem[rdPtr]};
            8'd2:    rdData = {30'h0, ctrl};
            default: rdData = 32'h0;
        endcase
    end

    // Registered read data and interrupt level, both reflecting state before this edge's updates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.dataOut <= 32'h0;
            irq         <= 1'b0;
        end else begin
            bus.dataOut <= rdData;
            irq         <= ctrl[1] && !fifoEmpty;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=8).
// Honours KEYPAD_RELEASE_EVENT_EN the same way as the design.
module tb_keypad_scan_ctrl;

    localparam int DEPTH = 8;
`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam bit REL_EV = 1'b1;
`else
    localparam bit REL_EV = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic        irq;
    logic [15:0] keys;

    int checks;
    int errors;

    // Behavioural model: committed mask, expected event queue, sticky overflow.
    logic [15:0] mStable;
    logic [4:0]  mQ[$];
    bit          mOvf;

    keypad_scan_ctrl_if bus();

    keypad_scan_ctrl #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave),
        .COL (COL),
        .ROW (ROW),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        COL = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (ROW[r] == 1'b0) begin
                COL = COL & ~keys[r*4 +: 4];
            end
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addrIn     = a;
        bus.dataIn     = d;
        bus.sizeDecode = 4'hF;
        @(posedge clk);
        #1;
        bus.sizeDecode = 4'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addrOut = a;
        @(posedge clk);
        #1;
        d = bus.dataOut;
    endtask

    task automatic hold_keys(input logic [15:0] k, input int cycles);
        keys = k;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Once the new matrix is committed, every changed key yields one event in ascending index order.
    task automatic model_commit(input logic [15:0] nk);
        for (int i = 0; i < 16; i++) begin
            if (mStable[i] != nk[i] && (nk[i] || REL_EV)) begin
                if (mQ.size() < DEPTH) mQ.push_back({nk[i], 4'(i)});
                else mOvf = 1'b1;
            end
        end
        mStable = nk;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ROW !== 4'hF) begin errors++; $display("[TB] FAIL reset_row: got %h expected f", ROW); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        checks++;
        if (bus.dataOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_dataout: got %h expected 0", bus.dataOut); end
        @(negedge clk);
        rstn = 1'b1;
        bus_read(8'd0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000000", rd); end
        bus_read(8'd1, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_event: got %h expected ffffffff", rd); end
        bus_read(8'd2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected 00000000", rd); end
        bus_read(8'd5, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected 00000000", rd); end
        checks++;
        if (ROW !== 4'hF || irq !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_outputs: row %h irq %b expected row f irq 0", ROW, irq);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] rd;
        bus_write(8'd2, 32'h3);
        hold_keys(16'h0000, 30);
        hold_keys(16'h0040, 15);
        hold_keys(16'h0000, 160);
        bus_read(8'd0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL glitch_status: got %h expected 00000000", rd); end
        bus_read(8'd1, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL glitch_event: got %h expected ffffffff", rd); end
    endtask

    task automatic test_press();
        logic [31:0] rd;
        hold_keys(16'h0040, 160);
        model_commit(16'h0040);
        bus_read(8'd0, rd);
        checks++;
        if (rd[31:16] !== 16'h0040) begin errors++; $display("[TB] FAIL press_mask: got %h expected 0040", rd[31:16]); end
        checks++;
        if (rd[11:8] !== 4'd1 || rd[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL press_count: got %0d/%b expected 1/1", rd[11:8], rd[0]);
        end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL press_irq: got %b expected 1", irq); end
        bus_read(8'd1, rd);
        checks++;
        if (rd !== 32'h16) begin errors++; $display("[TB] FAIL press_event: got %h expected 00000016", rd); end
        bus_write(8'd1, 32'h0);
        void'(mQ.pop_front());
        bus_read(8'd1, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL press_pop: got %h expected ffffffff", rd); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL press_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_release();
        logic [31:0] rd;
        hold_keys(16'h0000, 160);
        model_commit(16'h0000);
        bus_read(8'd0, rd);
        checks++;
        if (rd[31:16] !== 16'h0000) begin errors++; $display("[TB] FAIL release_mask: got %h expected 0000", rd[31:16]); end
        bus_read(8'd1, rd);
`ifdef KEYPAD_RELEASE_EVENT_EN
        checks++;
        if (rd !== 32'h06) begin errors++; $display("[TB] FAIL release_event: got %h expected 00000006", rd); end
        bus_write(8'd1, 32'h0);
        void'(mQ.pop_front());
`else
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL release_event: got %h expected ffffffff", rd); end
`endif
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [15:0] k;
        k = 16'h0;
        for (int i = 0; i < 9; i++) begin
            k[i] = 1'b1;
            hold_keys(k, 160);
            model_commit(k);
        end
        bus_read(8'd0, rd);
        checks++;
        if (rd[11:8] !== 4'd8) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 8", rd[11:8]); end
        checks++;
        if (rd[1] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", rd[1]); end
        bus_write(8'd2, 32'h7);
        mOvf = 1'b0;
        bus_read(8'd0, rd);
        checks++;
        if (rd[1] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", rd[1]); end
        bus_read(8'd2, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("[TB] FAIL ctrl_selfclear: got %h expected 00000003", rd); end
        while (mQ.size() > 0) begin
            bus_read(8'd1, rd);
            exp = {27'h0, mQ[0]};
            checks++;
            if (rd !== exp) begin errors++; $display("[TB] FAIL ovf_drain: got %h expected %h", rd, exp); end
            bus_write(8'd1, 32'h0);
            void'(mQ.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp;
        bit found;
        hold_keys(16'h0FFF, 160);
        model_commit(16'h0FFF);
        bus_read(8'd0, rd);
        checks++;
        if (rd[11:8] !== 4'd3) begin errors++; $display("[TB] FAIL b2b_setup_count: got %0d expected 3", rd[11:8]); end
        keys = 16'h4FFF;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(posedge clk);
            #1;
            if (ROW === 4'hF) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL b2b_emit_timeout: got no emit expected emit within 300 cycles");
            return;
        end
        // Key 14 is pushed at the end of the 15th EMIT cycle; pop on that same cycle.
        for (int j = 1; j <= 18; j++) begin
            @(posedge clk);
            #1;
            if (j == 14) begin
                bus.addrIn     = 8'd1;
                bus.sizeDecode = 4'hF;
            end
            if (j == 15) bus.sizeDecode = 4'h0;
            checks++;
            if (bus.dataOut[11:8] !== 4'd3) begin
                errors++; $display("[TB] FAIL b2b_count: cycle %0d got %0d expected 3", j, bus.dataOut[11:8]);
            end
        end
        void'(mQ.pop_front());
        model_commit(16'h4FFF);
        while (mQ.size() > 0) begin
            bus_read(8'd1, rd);
            exp = {27'h0, mQ[0]};
            checks++;
            if (rd !== exp) begin errors++; $display("[TB] FAIL b2b_drain: got %h expected %h", rd, exp); end
            bus_write(8'd1, 32'h0);
            void'(mQ.pop_front());
        end
    endtask

    task automatic test_disable();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #1;
            if (ROW !== 4'hF) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL disable_active: got row f expected scanning row");
            return;
        end
        bus_write(8'd2, 32'h2);
        @(posedge clk);
        #1;
        checks++;
        if (ROW !== 4'hF) begin errors++; $display("[TB] FAIL disable_row: got %h expected f", ROW); end
        hold_keys(keys, 30);
        checks++;
        if (ROW !== 4'hF) begin errors++; $display("[TB] FAIL disable_hold: got %h expected f", ROW); end
        bus_write(8'd2, 32'h3);
        @(posedge clk);
        #1;
        checks++;
        if (ROW !== 4'b1110) begin errors++; $display("[TB] FAIL reenable_row0: got %h expected e", ROW); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [15:0] k;
        for (int it = 0; it < 6; it++) begin
            k = 16'($urandom_range(0, 65535));
            hold_keys(k, 160);
            model_commit(k);
            bus_read(8'd0, rd);
            checks++;
            if (rd[31:16] !== mStable) begin errors++; $display("[TB] FAIL rand_mask: got %h expected %h", rd[31:16], mStable); end
            checks++;
            if (rd[11:8] !== 4'(mQ.size()) || rd[1] !== mOvf) begin
                errors++; $display("[TB] FAIL rand_status: got cnt %0d ovf %b expected cnt %0d ovf %b", rd[11:8], rd[1], mQ.size(), mOvf);
            end
            while (mQ.size() > 0) begin
                bus_read(8'd1, rd);
                exp = {27'h0, mQ[0]};
                checks++;
                if (rd !== exp) begin errors++; $display("[TB] FAIL rand_event: got %h expected %h", rd, exp); end
                bus_write(8'd1, 32'h0);
                void'(mQ.pop_front());
            end
            bus_read(8'd1, rd);
            checks++;
            if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rand_empty: got %h expected ffffffff", rd); end
            if (mOvf) begin
                bus_write(8'd2, 32'h7);
                mOvf = 1'b0;
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        keys           = 16'h0;
        mStable        = 16'h0;
        mOvf           = 1'b0;
        rstn           = 1'b0;
        bus.addrIn     = 8'h0;
        bus.addrOut    = 8'h0;
        bus.sizeDecode = 4'h0;
        bus.dataIn     = 32'h0;
        test_reset();
        test_glitch();
        test_press();
        test_release();
        test_overflow();
        test_back_to_back();
        test_disable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad on the memory-mapped peripheral bus. It sequences row strobes at a programmable rate, debounces the sampled key matrix over whole frames, and queues press/release events in a small FIFO that software reads and pops. It exposes a stable key mask, status bits and an interrupt level. It replaces free-running per-clock row rotation with a paced, debounced, software-visible controller.

## Interface
- SCAN_DIV, 1000, clocks each row is driven before sampling (min 4)
- DEBOUNCE_SCANS, 3, consecutive identical frames required to commit a new matrix (1..15)
- FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..16)

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- addrIn  in  8  write word address
- addrOut  in  8  read word address
- sizeDecode  in  4  byte write enables; any bit set = write to addrIn
- dataIn  in  32  write data
- dataOut  out  32  registered read data
- COL  in  4  column inputs, low = pressed
- ROW  out  4  row drive, one-hot low
- irq  out  1  level interrupt

## Operation
- Key index = row*4 + col; row r driven by ROW = ~(4'b0001 << r); pressed bit = ~COL[col].
- Registers (word address):
  - 0 STATUS (RO): [31:16] stable mask, [11:8] FIFO count, [1] overflow sticky, [0] FIFO non-empty.
  - 1 EVENT (RO): head entry {27'h0, press, code[3:0]}; 32'hFFFF_FFFF when empty. Any write to 1 pops one entry (no-op when empty).
  - 2 CTRL (RW): [0] scan enable, [1] irq enable; writing 1 to [2] clears overflow (self-clearing, reads 0).
  - Other addresses read 32'h0; writes ignored.
- Scan FSM: IDLE -> DRIVE (SCAN_DIV cycles) -> SAMPLE (1 cycle, capture row) -> next row DRIVE; after row 3 SAMPLE: debounce step, then EMIT if commit changed mask, else DRIVE row 0.
- IDLE: ROW = 4'b1111; entered when scan enable = 0, from any state, next cycle; on re-enable starts at row 0, frame buffer and debounce counter cleared, stable mask kept.
- Debounce: frame equal to previous frame -> counter++ (saturating); else counter = 1. When counter reaches DEBOUNCE_SCANS and frame != stable mask, stable <= frame.
- EMIT: 16 cycles, index 0..15 ascending; for each bit in (old ^ new) push {press = new bit, code = index}. ROW held 4'b1111 during EMIT.
- FIFO: push when full dropped and overflow set; push and pop in same cycle both take effect (count unchanged); pop on empty ignored.
- irq = CTRL[1] & non-empty, registered.

## Timing
- Reset values: ROW 4'b1111, dataOut 32'h0, irq 0, CTRL 0, stable mask 0, FIFO empty, overflow 0, FSM IDLE.
- Frame = 4*(SCAN_DIV+1) cycles (+16 when EMIT runs).
- Minimum press-to-FIFO latency: DEBOUNCE_SCANS frames after first sampled frame containing the key, +1..16 EMIT cycles.
- dataOut valid one cycle after addrOut; reflects state at that edge, including a pop in the same cycle (shows pre-pop head).
- Register writes take effect next cycle; irq follows FIFO state with 1-cycle delay.
- Reset asserted mid-scan or mid-EMIT: all state returns to reset values immediately; partial events discarded.

## Configuration
- KEYPAD_RELEASE_EVENT_EN defined: both press (press=1) and release (press=0) events enqueued.
- Undefined: only press events enqueued; released bits still update stable mask; EMIT still runs 16 cycles.

## Test plan
- Reset with scan disabled -> ROW = 4'b1111, STATUS = 0, EVENT = 32'hFFFF_FFFF, irq = 0.
- SCAN_DIV=4, DEBOUNCE_SCANS=2, CTRL=3, hold key 6 (row 1, col 2) -> after 2 frames STATUS[31:16]=16'h0040, EVENT=32'h16, irq=1; write addr 1 -> EVENT=32'hFFFF_FFFF, irq=0.
- Key 6 glitch lasting one frame -> no commit, FIFO empty, stable mask 0.
- Release key 6 with macro defined -> EVENT=32'h06; without macro -> FIFO empty, mask 0.
- FIFO_DEPTH=8, 9 distinct press commits without pops -> count 8, overflow=1; write CTRL=32'h7 -> overflow 0.
- Simultaneous push (EMIT) and pop write with count 3 -> count stays 3; disable scan mid-DRIVE -> ROW=4'b1111 next cycle.
